regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side feeder for the 32x32 MIPS register file.
- Accepts register write requests from late-completing units (multi-cycle loads, mult/div) over a valid/ready handshake.
- Buffers requests in order in a small FIFO and drains one per cycle onto the register file write port (RegWrite, WriteRegister, WriteData).
- Optionally exposes pending-write lookups so the operand-read stage can bypass data that is not yet written.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2
PTR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
Clk  input  1  clock; all state updates on the positive edge
Rst_n  input  1  reset; asynchronous assert, active low
InValid  input  1  write request valid
InReady  output  1  queue can accept a request this cycle
InAddr  input  5  destination register address
InData  input  32  data to write
Hold  input  1  when high, suppresses draining
RegWrite  output  1  write enable to the register file
WriteRegister  output  5  write address to the register file
WriteData  output  32  write data to the register file
Empty  output  1  FIFO and output stage both idle
Count  output  PTR_W+1  number of FIFO entries currently held
LookupAddr1  input  5  bypass lookup address, port 1 (only with the optional feature)
LookupAddr2  input  5  bypass lookup address, port 2 (only with the optional feature)
FwdHit1  output  1  pending write matches LookupAddr1 (only with the optional feature)
FwdHit2  output  1  pending write matches LookupAddr2 (only with the optional feature)
FwdData1  output  32  newest pending data for LookupAddr1 (only with the optional feature)
FwdData2  output  32  newest pending data for LookupAddr2 (only with the optional feature)

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Pointers and Count go to 0.
  - RegWrite, WriteRegister and WriteData go to 0.
  - Empty goes to 1; InReady goes to 1.
  - Contents in flight are discarded. Reset mid-drain cancels the pending write.
- Input handshake:
  - InReady = (Count != DEPTH). It is combinational on Count only, never on a same-cycle pop.
  - A request is accepted on an edge where InValid and InReady are both high.
  - InValid with InReady low is ignored. The producer holds the request until it is accepted.
- Register $0:
  - A request with InAddr == 0 is accepted (the handshake completes) but not enqueued.
  - It never produces RegWrite.
- Output stage:
  - The write-port signals are registered.
  - On each edge, if Hold is low and Count > 0, the head is popped into WriteRegister/WriteData and RegWrite is set to 1 for exactly one cycle.
  - Otherwise RegWrite goes to 0. WriteRegister and WriteData keep their last values.
- Latency:
  - A request accepted at edge N into an empty queue appears with RegWrite high during cycle N+1.
  - The register file commits it at edge N+2.
  - There is no same-cycle bypass from input to output.
- Simultaneous push and pop: allowed when not full. Count is unchanged.
- Full: a pop frees a slot; InReady rises the following cycle.
- Wrap-around: pointers are PTR_W bits and wrap modulo DEPTH. Count is PTR_W+1 bits.
- Hold: freezes the FIFO head and forces RegWrite low. Pushes continue until full.
- Ordering: strictly FIFO. Two writes to the same register commit oldest first.
- Empty = (Count == 0) and RegWrite is low.

Optional Feature:
- Macro: REGFILE_WB_QUEUE_FWD_EN.
- When defined:
  - FwdHitK/FwdDataK (K = 1, 2) are combinational.
  - Search set: all FIFO entries plus the output stage while RegWrite is high.
  - The newest matching entry wins (FIFO tail side over head side, FIFO over output stage).
  - LookupAddrK == 0 never hits. On a miss, FwdDataK = 0.
- When undefined: the lookup ports are absent, and no comparators or priority logic are built.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0.
  - A wb_entry typedef (addr, data).
- One natural sub-module, regfile_wb_match: a single lookup port's newest-match priority search. It is instantiated twice under the macro.

Test Plan:
- Single write: push (3, 0xDEADBEEF) into an empty queue -> RegWrite high for exactly one cycle, next cycle, with WriteRegister=3 and WriteData=0xDEADBEEF; Empty returns to 1.
- $0 drop: push (0, 0x12345678) -> accepted, Count stays 0, RegWrite never asserts.
- Fill and backpressure: with Hold=1, push 5 requests at DEPTH=4 -> InReady low after the 4th, 5th held; release Hold -> writes drain in order on 4 consecutive cycles, 5th accepted the cycle after the first pop.
- Same-register ordering plus bypass (macro on): push (7, 0x1), then (7, 0x2), with Hold=1 and LookupAddr1=7 -> FwdHit1=1, FwdData1=0x2; drain -> commits 0x1 then 0x2.
- Wrap-around: 10 push/pop pairs with mixed Hold -> output sequence equals input sequence; Count never exceeds 4.
- Reset mid-drain: assert Rst_n=0 with 3 entries queued and RegWrite high -> RegWrite, WriteRegister, WriteData, Count go to 0 immediately; no writes follow release.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the MIPS register-file write-back queue.
// Holds the register address/data widths, the hard-wired zero register
// address, and the wb_entry record that travels through the queue.
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register write: destination and value
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry;

endpackage

// File: rtl/regfile_wb_match.sv
// ---------------------------------------------------------------------------
// regfile_wb_match
// Newest-match search for one bypass lookup port. Looks through the valid
// FIFO entries and the output stage and returns the data of the youngest
// pending write to the requested register.
// Only instantiated when REGFILE_WB_QUEUE_FWD_EN is defined.
// Ports:
//   i_entries    FIFO storage (all DEPTH slots, validity from ptr/count)
//   i_rdPtr      FIFO head index (oldest entry)
//   i_count      number of valid FIFO entries
//   i_outValid   output stage currently holds a write (RegWrite high)
//   i_outEntry   output stage address/data
//   i_lookupAddr register being read by the operand stage
//   o_hit        a pending write to i_lookupAddr exists
//   o_data       newest pending data, 0 on a miss
// ---------------------------------------------------------------------------
module regfile_wb_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wb_entry                 i_entries [DEPTH],
  input  logic [PTR_W-1:0]        i_rdPtr,
  input  logic [PTR_W:0]          i_count,
  input  logic                    i_outValid,
  input  wb_entry                 i_outEntry,
  input  logic [REG_ADDR_W-1:0]   i_lookupAddr,
  output logic                    o_hit,
  output logic [REG_DATA_W-1:0]   o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk from oldest to newest so that a later match overrides an earlier
  // one: output stage first, then FIFO head towards tail. Register $0 is
  // never written, so it never hits.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    if (i_lookupAddr != REG_ZERO) begin
      if (i_outValid && (i_outEntry.addr == i_lookupAddr)) begin
        o_hit  = 1'b1;
        o_data = i_outEntry.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = i_rdPtr + PTR_W'(i);
        if (((PTR_W+1)'(i) < i_count) && (i_entries[w_idx].addr == i_lookupAddr)) begin
          o_hit  = 1'b1;
          o_data = i_entries[w_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
// Write-side feeder for the 32x32 MIPS register file. Late-completing units
// hand in register writes over a valid/ready handshake; the writes are kept
// in order in a small FIFO and drained one per cycle onto the registered
// register-file write port.
// Optional feature macro: REGFILE_WB_QUEUE_FWD_EN adds two combinational
// lookup ports that report the newest pending write for a register.
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   InValid/InReady       request handshake
//   InAddr/InData         request destination register and value
//   Hold                  stalls draining while high
//   RegWrite/WriteRegister/WriteData  registered register-file write port
//   Empty                 no queued entries and no write in the output stage
//   Count                 number of FIFO entries held
//   LookupAddrK/FwdHitK/FwdDataK (K=1,2, macro only) bypass lookups
// ---------------------------------------------------------------------------
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [REG_ADDR_W-1:0] InAddr,
  input  logic [REG_DATA_W-1:0] InData,
  input  logic                  Hold,
`ifdef REGFILE_WB_QUEUE_FWD_EN
  input  logic [REG_ADDR_W-1:0] LookupAddr1,
  input  logic [REG_ADDR_W-1:0] LookupAddr2,
  output logic                  FwdHit1,
  output logic                  FwdHit2,
  output logic [REG_DATA_W-1:0] FwdData1,
  output logic [REG_DATA_W-1:0] FwdData2,
`endif
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [REG_DATA_W-1:0] WriteData,
  output logic                  Empty,
  output logic [PTR_W:0]        Count
);

  wb_entry               r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W:0]        r_count;
  logic                  r_regWrite;
  logic [REG_ADDR_W-1:0] r_writeRegister;
  logic [REG_DATA_W-1:0] r_writeData;

  logic w_accept;
  logic w_push;
  logic w_pop;

  // Ready depends on the stored count only, so a pop in the same cycle never
  // opens a slot early. Writes to $0 complete the handshake but are dropped.
  assign InReady  = (r_count != (PTR_W+1)'(DEPTH));
  assign w_accept = InValid && InReady;
  assign w_push   = w_accept && (InAddr != REG_ZERO);
  assign w_pop    = !Hold && (r_count != '0);

  // Storage needs no reset: validity is tracked entirely by pointers/count
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= '{addr: InAddr, data: InData};
    end
  end

  // Pointers wrap naturally at PTR_W bits; count moves only when exactly one
  // of push/pop happens
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port: the popped head is presented for one cycle;
  // address/data are kept afterwards, only the enable drops
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_regWrite      <= 1'b0;
      r_writeRegister <= '0;
      r_writeData     <= '0;
    end else if (w_pop) begin
      r_regWrite      <= 1'b1;
      r_writeRegister <= r_mem[r_rdPtr].addr;
      r_writeData     <= r_mem[r_rdPtr].data;
    end else begin
      r_regWrite      <= 1'b0;
    end
  end

  assign RegWrite      = r_regWrite;
  assign WriteRegister = r_writeRegister;
  assign WriteData     = r_writeData;
  assign Count         = r_count;
  assign Empty         = (r_count == '0) && !r_regWrite;

`ifdef REGFILE_WB_QUEUE_FWD_EN
  wb_entry w_outEntry;
  assign w_outEntry = '{addr: r_writeRegister, data: r_writeData};

  regfile_wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uMatch1 (
    .i_entries    (r_mem),
    .i_rdPtr      (r_rdPtr),
    .i_count      (r_count),
    .i_outValid   (r_regWrite),
    .i_outEntry   (w_outEntry),
    .i_lookupAddr (LookupAddr1),
    .o_hit        (FwdHit1),
    .o_data       (FwdData1)
  );

  regfile_wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uMatch2 (
    .i_entries    (r_mem),
    .i_rdPtr      (r_rdPtr),
    .i_count      (r_count),
    .i_outValid   (r_regWrite),
    .i_outEntry   (w_outEntry),
    .i_lookupAddr (LookupAddr2),
    .o_hit        (FwdHit2),
    .o_data       (FwdData2)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
// Self-checking bench for regfile_wb_queue. Accepted writes are pushed to a
// scoreboard queue; a monitor pops and compares them whenever RegWrite is
// seen. Lookup checks are built when REGFILE_WB_QUEUE_FWD_EN is defined.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InAddr;
  logic [31:0] InData;
  logic        Hold;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Empty;
  logic [2:0]  Count;
`ifdef REGFILE_WB_QUEUE_FWD_EN
  logic [4:0]  LookupAddr1;
  logic [4:0]  LookupAddr2;
  logic        FwdHit1;
  logic        FwdHit2;
  logic [31:0] FwdData1;
  logic [31:0] FwdData2;
`endif

  int checks   = 0;
  int failures = 0;
  wb_entry sbQ[$];

  regfile_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .InValid       (InValid),
    .InReady       (InReady),
    .InAddr        (InAddr),
    .InData        (InData),
    .Hold          (Hold),
`ifdef REGFILE_WB_QUEUE_FWD_EN
    .LookupAddr1   (LookupAddr1),
    .LookupAddr2   (LookupAddr2),
    .FwdHit1       (FwdHit1),
    .FwdHit2       (FwdHit2),
    .FwdData1      (FwdData1),
    .FwdData2      (FwdData2),
`endif
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Empty         (Empty),
    .Count         (Count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request and hold it until accepted; non-$0 writes are
  // recorded as expected register-file commits
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    int waitCycles;
    waitCycles = 0;
    InValid = 1'b1;
    InAddr  = a;
    InData  = d;
    while (!InReady && waitCycles < 20) begin
      @(posedge Clk); #1;
      waitCycles++;
    end
    checkOutput("pushAccept", {31'b0, InReady}, 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    if (a != 5'd0) sbQ.push_back('{addr: a, data: d});
  endtask

  // Bounded wait until the queue is idle and every expected write was seen
  task automatic waitDrain();
    int n;
    n = 0;
    while (!(Empty && sbQ.size() == 0) && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    checkOutput("drainDone", {31'b0, (Empty && sbQ.size() == 0)}, 32'd1);
  endtask

  // Monitor: every RegWrite cycle must match the oldest expected write;
  // Count must never exceed the FIFO depth
  always @(negedge Clk) begin
    if (Rst_n) begin
      checkOutput("countBound", {31'b0, (Count <= 3'd4)}, 32'd1);
      if (RegWrite) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedWrite", {27'b0, WriteRegister}, 32'hFFFF_FFFF);
        end else begin
          wb_entry e;
          e = sbQ.pop_front();
          checkOutput("wrAddr", {27'b0, WriteRegister}, {27'b0, e.addr});
          checkOutput("wrData", WriteData, e.data);
        end
      end
    end
  end

  initial begin
    Rst_n   = 1'b1;
    InValid = 1'b0;
    InAddr  = '0;
    InData  = '0;
    Hold    = 1'b0;
`ifdef REGFILE_WB_QUEUE_FWD_EN
    LookupAddr1 = '0;
    LookupAddr2 = '0;
`endif

    // Reset state
    #1 Rst_n = 1'b0;
    #1;
    checkOutput("rstRegWrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("rstWrReg", {27'b0, WriteRegister}, 32'd0);
    checkOutput("rstWrData", WriteData, 32'd0);
    checkOutput("rstCount", {29'b0, Count}, 32'd0);
    checkOutput("rstEmpty", {31'b0, Empty}, 32'd1);
    checkOutput("rstInReady", {31'b0, InReady}, 32'd1);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Single write: one cycle latency into the output stage
    applyStimulus(5'd3, 32'hDEAD_BEEF);
    checkOutput("single.count", {29'b0, Count}, 32'd1);
    checkOutput("single.noBypass", {31'b0, RegWrite}, 32'd0);
    checkOutput("single.notEmpty", {31'b0, Empty}, 32'd0);
    @(posedge Clk); #1;
    checkOutput("single.regWrite", {31'b0, RegWrite}, 32'd1);
    checkOutput("single.addr", {27'b0, WriteRegister}, 32'd3);
    checkOutput("single.data", WriteData, 32'hDEAD_BEEF);
    @(posedge Clk); #1;
    checkOutput("single.oneCycle", {31'b0, RegWrite}, 32'd0);
    checkOutput("single.keepAddr", {27'b0, WriteRegister}, 32'd3);
    checkOutput("single.empty", {31'b0, Empty}, 32'd1);

    // $0 request is accepted but dropped
    applyStimulus(5'd0, 32'h1234_5678);
    checkOutput("zero.count", {29'b0, Count}, 32'd0);
    repeat (3) begin
      @(posedge Clk); #1;
      checkOutput("zero.noWrite", {31'b0, RegWrite}, 32'd0);
    end

    // Fill under Hold, then backpressure on the fifth request
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(5'(10 + i), 32'hA0 + 32'(i));
    checkOutput("fill.count", {29'b0, Count}, 32'd4);
    checkOutput("fill.notReady", {31'b0, InReady}, 32'd0);
    InValid = 1'b1;
    InAddr  = 5'd14;
    InData  = 32'hE5;
    @(posedge Clk); #1;
    checkOutput("fill.held", {29'b0, Count}, 32'd4);
    checkOutput("fill.holdNoWrite", {31'b0, RegWrite}, 32'd0);
    Hold = 1'b0;
    @(posedge Clk); #1;
    checkOutput("fill.pop1", {31'b0, RegWrite}, 32'd1);
    checkOutput("fill.pop1Count", {29'b0, Count}, 32'd3);
    checkOutput("fill.readyAgain", {31'b0, InReady}, 32'd1);
    @(posedge Clk); #1;
    sbQ.push_back('{addr: 5'd14, data: 32'hE5});
    InValid = 1'b0;
    checkOutput("fill.pushPopCount", {29'b0, Count}, 32'd3);
    checkOutput("fill.pop2", {31'b0, RegWrite}, 32'd1);
    repeat (3) begin
      @(posedge Clk); #1;
      checkOutput("fill.drain", {31'b0, RegWrite}, 32'd1);
    end
    @(posedge Clk); #1;
    checkOutput("fill.done", {31'b0, RegWrite}, 32'd0);
    checkOutput("fill.empty", {31'b0, Empty}, 32'd1);

    // Same-register ordering (and bypass when built in)
    Hold = 1'b1;
    applyStimulus(5'd7, 32'h1);
    applyStimulus(5'd7, 32'h2);
`ifdef REGFILE_WB_QUEUE_FWD_EN
    LookupAddr1 = 5'd7;
    LookupAddr2 = 5'd0;
    #1;
    checkOutput("fwd.hit1", {31'b0, FwdHit1}, 32'd1);
    checkOutput("fwd.data1", FwdData1, 32'h2);
    checkOutput("fwd.zeroHit", {31'b0, FwdHit2}, 32'd0);
    checkOutput("fwd.zeroData", FwdData2, 32'd0);
    LookupAddr2 = 5'd9;
    #1;
    checkOutput("fwd.missHit", {31'b0, FwdHit2}, 32'd0);
    checkOutput("fwd.missData", FwdData2, 32'd0);
`endif
    Hold = 1'b0;
    @(posedge Clk); #1;
    checkOutput("order.first", WriteData, 32'h1);
`ifdef REGFILE_WB_QUEUE_FWD_EN
    checkOutput("fwd.fifoOverOut", FwdData1, 32'h2);
`endif
    @(posedge Clk); #1;
    checkOutput("order.second", WriteData, 32'h2);
`ifdef REGFILE_WB_QUEUE_FWD_EN
    checkOutput("fwd.outStage", FwdData1, 32'h2);
    LookupAddr1 = 5'd0;
    LookupAddr2 = 5'd0;
`endif
    waitDrain();

    // Wrap-around with mixed Hold
    for (int i = 0; i < 10; i++) begin
      Hold = (i % 3 == 1);
      applyStimulus(5'(i + 1), $urandom);
    end
    Hold = 1'b0;
    waitDrain();

    // Reset mid-drain cancels the pending write and the queued entries
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(5'(20 + i), 32'hC0 + 32'(i));
    Hold = 1'b0;
    @(posedge Clk); #1;
    checkOutput("rst2.writing", {31'b0, RegWrite}, 32'd1);
    Rst_n = 1'b0;
    #1;
    checkOutput("rst2.regWrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("rst2.wrReg", {27'b0, WriteRegister}, 32'd0);
    checkOutput("rst2.wrData", WriteData, 32'd0);
    checkOutput("rst2.count", {29'b0, Count}, 32'd0);
    checkOutput("rst2.empty", {31'b0, Empty}, 32'd1);
    sbQ.delete();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    repeat (4) begin
      @(posedge Clk); #1;
      checkOutput("rst2.noWrite", {31'b0, RegWrite}, 32'd0);
    end
    checkOutput("rst2.countAfter", {29'b0, Count}, 32'd0);

    checkOutput("sbEmpty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
